// File: rtl/irq_controller.sv
// External interrupt controller: synchronises and latches peripheral requests,
// requests the cpu, and supplies the pending word during the acknowledge cycle.
module irq_controller #(
  parameter int          NSRC      = 64,
  parameter logic [63:0] EDGE_MASK = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          HOLDOFF   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] i_src,
  input  logic            i_mask_wr,
  input  logic [63:0]     i_mask_data,
  input  logic            i_clr_wr,
  input  logic [63:0]     i_clr_data,
  input  logic            i_iack,
  output logic            o_irq,
  output logic [63:0]     o_vector,
  output logic            o_ack_valid,
  output logic [63:0]     o_pending
);

  typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;

  state_t      state_reg;
  logic [63:0] mask_reg;
  logic [63:0] vector_reg;
  logic        irq_reg;
  logic        ack_valid_reg;
  logic [3:0]  holdoff_reg;

  logic [63:0] pending_bits;
  logic [63:0] active;
  logic [63:0] clr_bits;
  logic        ack_release;

  assign active      = pending_bits & mask_reg;
  assign ack_release = (state_reg == ACK) && !i_iack;
  // Software clear and end-of-acknowledge clear share one path; a new edge still wins.
  assign clr_bits    = (i_clr_wr ? i_clr_data : 64'd0) | (ack_release ? vector_reg : 64'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi = gi + 1) begin : g_src
      if (gi < NSRC) begin : g_used
        logic sync1_reg;
        logic sync2_reg;
        logic sync3_reg;
        logic pend_reg;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
          end else begin
            sync1_reg <= i_src[gi];
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
          end
        end

        if (EDGE_MASK[gi]) begin : g_edge
          always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
              pend_reg <= 1'b0;
            end else if (sync2_reg && !sync3_reg) begin
              pend_reg <= 1'b1;
            end else if (clr_bits[gi]) begin
              pend_reg <= 1'b0;
            end
          end
        end else begin : g_level
          // Level sources simply mirror the synchronised line.
          always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
              pend_reg <= 1'b0;
            end else begin
              pend_reg <= sync2_reg;
            end
          end
        end

        assign pending_bits[gi] = pend_reg;
      end else begin : g_unused
        assign pending_bits[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= 64'd0;
    end else if (i_mask_wr) begin
      mask_reg <= i_mask_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      irq_reg       <= 1'b0;
      ack_valid_reg <= 1'b0;
      vector_reg    <= 64'd0;
      holdoff_reg   <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A spurious acknowledge reads an empty vector and blocks new requests.
          ack_valid_reg <= i_iack;
          if (i_iack) begin
            vector_reg <= 64'd0;
          end else if (active != 64'd0 && holdoff_reg == 4'd0) begin
            state_reg <= REQ;
            irq_reg   <= 1'b1;
          end
        end
        REQ: begin
          if (active == 64'd0) begin
            state_reg <= IDLE;
            irq_reg   <= 1'b0;
          end else if (i_iack) begin
            state_reg     <= ACK;
            irq_reg       <= 1'b0;
            ack_valid_reg <= 1'b1;
            vector_reg    <= active;
          end
        end
        ACK: begin
          if (!i_iack) begin
            state_reg     <= HOLD;
            ack_valid_reg <= 1'b0;
            vector_reg    <= 64'd0;
            holdoff_reg   <= 4'(HOLDOFF);
          end
        end
        HOLD: begin
          ack_valid_reg <= i_iack;
          if (i_iack) begin
            vector_reg <= 64'd0;
          end
          if (holdoff_reg <= 4'd1) begin
            // Last hold-off cycle: re-request directly so o_irq is low for exactly HOLDOFF clocks.
            holdoff_reg <= 4'd0;
            if (active != 64'd0 && !i_iack) begin
              state_reg <= REQ;
              irq_reg   <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            holdoff_reg <= holdoff_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          irq_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign o_irq       = irq_reg;
  assign o_ack_valid = ack_valid_reg;
  assign o_vector    = vector_reg;
  assign o_pending   = pending_bits;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: edge/level latching, masking, acknowledge
// snapshot, clear priority, hold-off timing, reset and spurious acknowledge.
module tb_irq_controller;

  logic        clk;
  logic        reset_n;
  logic [63:0] i_src;
  logic        i_mask_wr;
  logic [63:0] i_mask_data;
  logic        i_clr_wr;
  logic [63:0] i_clr_data;
  logic        i_iack;
  logic        o_irq;
  logic [63:0] o_vector;
  logic        o_ack_valid;
  logic [63:0] o_pending;

  int n_cmp = 0;
  int n_err = 0;

  irq_controller #(
    .NSRC      (64),
    .EDGE_MASK (64'hFFFF_FFFF_FFFF_FFF7),
    .HOLDOFF   (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_src       (i_src),
    .i_mask_wr   (i_mask_wr),
    .i_mask_data (i_mask_data),
    .i_clr_wr    (i_clr_wr),
    .i_clr_data  (i_clr_data),
    .i_iack      (i_iack),
    .o_irq       (o_irq),
    .o_vector    (o_vector),
    .o_ack_valid (o_ack_valid),
    .o_pending   (o_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %-16s observed %h expected %h", tag, obs, exp);
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_mask(input logic [63:0] m);
    i_mask_wr   = 1'b1;
    i_mask_data = m;
    tick();
    i_mask_wr   = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b1;
    i_src       = 64'd0;
    i_mask_wr   = 1'b0;
    i_mask_data = 64'd0;
    i_clr_wr    = 1'b0;
    i_clr_data  = 64'd0;
    i_iack      = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_irq", {63'd0, o_irq}, 64'd0);
    check("rst_ackv", {63'd0, o_ack_valid}, 64'd0);
    check("rst_vector", o_vector, 64'd0);
    check("rst_pending", o_pending, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 1: edge pulses on bits 0,2,5,7
    write_mask(64'hFF);
    i_src = 64'hA5;
    tick();
    i_src = 64'd0;
    tick();
    check("t1_pend_early", o_pending, 64'd0);
    tick();
    check("t1_pend", o_pending, 64'hA5);
    check("t1_irq_early", {63'd0, o_irq}, 64'd0);
    tick();
    check("t1_irq", {63'd0, o_irq}, 64'd1);

    // 2: acknowledge held 3 clocks, then hold-off
    i_iack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_vector", o_vector, 64'hA5);
      check("t2_ackv", {63'd0, o_ack_valid}, 64'd1);
      check("t2_irq", {63'd0, o_irq}, 64'd0);
    end
    i_iack = 1'b0;
    tick();
    check("t2_pend_clr", o_pending, 64'd0);
    check("t2_ackv_off", {63'd0, o_ack_valid}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_irq_hold", {63'd0, o_irq}, 64'd0);
    end

    // 3: level source on bit 3, masked then unmasked
    i_mask_wr   = 1'b1;
    i_mask_data = 64'h01;
    i_src       = 64'h08;
    tick();
    i_mask_wr = 1'b0;
    tick();
    tick();
    check("t3_pend", o_pending, 64'h08);
    check("t3_irq_masked", {63'd0, o_irq}, 64'd0);
    tick();
    check("t3_irq_masked2", {63'd0, o_irq}, 64'd0);
    write_mask(64'h08);
    check("t3_irq_wr", {63'd0, o_irq}, 64'd0);
    tick();
    check("t3_irq", {63'd0, o_irq}, 64'd1);
    i_iack = 1'b1;
    tick();
    check("t3_vector", o_vector, 64'h08);
    i_iack = 1'b0;
    tick();
    check("t3_pend_level", o_pending, 64'h08);
    check("t3_irq_hold0", {63'd0, o_irq}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_irq_hold", {63'd0, o_irq}, 64'd0);
    end
    tick();
    check("t3_rereq", {63'd0, o_irq}, 64'd1);
    i_src = 64'd0;
    tick();
    tick();
    tick();
    check("t3_level_drop", o_pending, 64'd0);
    tick();
    check("t3_irq_drop", {63'd0, o_irq}, 64'd0);

    // 4: software clear in REQ, then clear colliding with a new edge
    write_mask(64'h02);
    i_src = 64'h02;
    tick();
    i_src = 64'd0;
    tick();
    tick();
    check("t4_pend", o_pending, 64'h02);
    tick();
    check("t4_irq", {63'd0, o_irq}, 64'd1);
    i_clr_wr   = 1'b1;
    i_clr_data = 64'h02;
    tick();
    i_clr_wr = 1'b0;
    check("t4_pend_clr", o_pending, 64'd0);
    check("t4_irq_still", {63'd0, o_irq}, 64'd1);
    tick();
    check("t4_irq_drop", {63'd0, o_irq}, 64'd0);
    i_src = 64'h02;
    tick();
    i_src = 64'd0;
    tick();
    i_clr_wr = 1'b1;
    tick();
    i_clr_wr = 1'b0;
    check("t4_set_wins", o_pending, 64'h02);
    tick();
    i_clr_wr = 1'b1;
    tick();
    i_clr_wr = 1'b0;
    tick();
    check("t4_quiet", {63'd0, o_irq}, 64'd0);

    // 5: new edge during acknowledge
    write_mask(64'h11);
    i_src = 64'h01;
    tick();
    i_src = 64'd0;
    tick();
    tick();
    check("t5_pend", o_pending, 64'h01);
    tick();
    check("t5_irq", {63'd0, o_irq}, 64'd1);
    i_iack = 1'b1;
    tick();
    check("t5_vector", o_vector, 64'h01);
    i_src = 64'h10;
    tick();
    i_src = 64'd0;
    tick();
    tick();
    check("t5_pend_ack", o_pending, 64'h11);
    check("t5_vector_held", o_vector, 64'h01);
    check("t5_ackv", {63'd0, o_ack_valid}, 64'd1);
    i_iack = 1'b0;
    tick();
    check("t5_pend_rel", o_pending, 64'h10);
    check("t5_irq_hold0", {63'd0, o_irq}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_irq_hold", {63'd0, o_irq}, 64'd0);
    end
    tick();
    check("t5_rereq", {63'd0, o_irq}, 64'd1);
    i_iack = 1'b1;
    tick();
    check("t5_vector2", o_vector, 64'h10);

    // 6: reset in the middle of an acknowledge, then spurious acknowledge
    reset_n = 1'b0;
    i_iack  = 1'b0;
    #1;
    check("t6_irq", {63'd0, o_irq}, 64'd0);
    check("t6_ackv", {63'd0, o_ack_valid}, 64'd0);
    check("t6_vector", o_vector, 64'd0);
    check("t6_pending", o_pending, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    i_iack = 1'b1;
    tick();
    check("t6_sp_ackv", {63'd0, o_ack_valid}, 64'd1);
    check("t6_sp_vector", o_vector, 64'd0);
    tick();
    check("t6_sp_ackv2", {63'd0, o_ack_valid}, 64'd1);
    check("t6_sp_irq", {63'd0, o_irq}, 64'd0);
    i_iack = 1'b0;
    tick();
    check("t6_sp_end", {63'd0, o_ack_valid}, 64'd0);
    i_src = 64'h01;
    tick();
    i_src = 64'd0;
    tick();
    tick();
    check("t6_pend_masked", o_pending, 64'h01);
    tick();
    check("t6_mask_rst", {63'd0, o_irq}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
